// File: rtl/ss_seq.sv
// Save-state sequencer: walks mapper slots over the ss_* strobe bus, streaming them to the host
// on save, or writing a host byte stream back into the mapper on restore.
module ss_seq #(
  parameter int NSLOT   = 18,
  parameter int ID_ADDR = 127,
  parameter int HALF    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       ss_m2
);

  localparam int PW = $clog2(2 * HALF);
  localparam logic [7:0] ID8 = 8'(ID_ADDR);
  localparam logic [7:0] LAST = 8'(NSLOT - 1);

  typedef enum logic [3:0] {
    IDLE, HDR_RD, HDR_TX, HDR_CMP, SL_RD, SL_TX, SL_RX, SL_WR, FIN
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ph;
  logic [7:0]      r_cnt;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdat;
  logic [7:0]      r_id;
  logic [7:0]      r_byte;
  logic            r_we;
  logic            r_m2;
  logic            r_err;
  logic            r_mode;
  logic            w_bus;
  logic            w_samp;
  logic            w_end;
  logic            w_last;

  assign w_bus  = (r_state == HDR_RD) || (r_state == SL_RD) || (r_state == SL_WR);
  assign w_samp = (r_ph == PW'(HALF - 1));
  assign w_end  = (r_ph == PW'(2 * HALF - 1));
  assign w_last = (r_cnt == LAST);

  assign ss_we   = r_we;
  assign ss_addr = r_addr;
  assign ss_wdat = r_wdat;
  assign ss_m2   = r_m2;
  assign err     = r_err;

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    ss_act   = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    tx_data  = (r_state == HDR_TX) ? r_id : r_byte;
    unique case (r_state)
      IDLE:    if (start) w_next = HDR_RD;
      HDR_RD:  if (w_end) w_next = r_mode ? HDR_CMP : HDR_TX;
      HDR_TX:  if (tx_ready) w_next = SL_RD;
      SL_RD:   if (w_end) w_next = SL_TX;
      SL_TX:   if (tx_ready) w_next = w_last ? FIN : SL_RD;
      HDR_CMP: if (rx_valid) w_next = (rx_data == r_id) ? SL_RX : FIN;
      SL_RX:   if (rx_valid) w_next = SL_WR;
      SL_WR:   if (w_end) w_next = w_last ? FIN : SL_RX;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE && r_state != FIN) begin
      busy   = 1'b1;
      ss_act = 1'b1;
    end
    if (r_state == FIN) done = 1'b1;
    if (r_state == HDR_TX || r_state == SL_TX) tx_valid = 1'b1;
    if (r_state == HDR_CMP || r_state == SL_RX) rx_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_we    <= 1'b0;
      r_m2    <= 1'b1;
      r_err   <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      // strobe phase: high for HALF clocks from setup, low for HALF, we released at the end
      if (w_bus) begin
        r_ph <= w_end ? '0 : r_ph + PW'(1);
        if (w_samp) r_m2 <= 1'b0;
        if (w_end) begin
          r_m2 <= 1'b1;
          r_we <= 1'b0;
        end
      end
      unique case (r_state)
        IDLE: if (start) begin
          r_err  <= 1'b0;
          r_cnt  <= '0;
          r_mode <= mode;
          r_addr <= ID8;
        end
        HDR_TX: if (tx_ready) r_addr <= r_cnt;
        SL_TX: if (tx_ready && !w_last) begin
          r_cnt  <= r_cnt + 8'd1;
          r_addr <= r_cnt + 8'd1;
        end
        HDR_CMP: if (rx_valid && rx_data != r_id) r_err <= 1'b1;
        SL_RX: if (rx_valid) begin
          r_wdat <= rx_data;
          r_addr <= r_cnt;
          r_we   <= 1'b1;
        end
        SL_WR: if (w_end && !w_last) r_cnt <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // read data is captured on the last high-phase clock
  always_ff @(posedge clk) begin
    if (r_state == HDR_RD && w_samp) r_id <= ss_rdat;
    if (r_state == SL_RD && w_samp) r_byte <= ss_rdat;
  end

endmodule

// File: tb/tb_ss_seq.sv
// Randomized scoreboard bench for ss_seq with a behavioural mapper and host stream model.
module tb_ss_seq;
  localparam int NSLOT = 18;
  localparam int ID_ADDR = 127;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy, done, err, tx_valid, rx_ready, ss_act, ss_we, ss_m2;
  logic [7:0] tx_data, ss_addr, ss_wdat, ss_rdat;

  logic [7:0]  mem [256];
  logic [7:0]  exp_tx [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  rx_q [$];
  logic [7:0]  pay [NSLOT];

  int checks = 0;
  int errors = 0;
  int n_tx = 0, n_wr = 0, n_rx = 0, n_done = 0, cyc = 0;
  int tx_mode = 0;
  int rx_gap = 0;
  int stab = 0;
  logic [7:0] p_addr = 8'h00, p_wdat = 8'h00, p_txd = 8'h00;
  logic       p_we = 1'b0, p_m2 = 1'b1, p_txv = 1'b0, p_xfer = 1'b0;

  ss_seq #(.NSLOT(NSLOT), .ID_ADDR(ID_ADDR), .HALF(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .ss_rdat(ss_rdat), .ss_m2(ss_m2)
  );

  assign ss_rdat = mem[ss_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Mapper, host-side stream driver and output monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if ({ss_addr, ss_wdat, ss_we} === {p_addr, p_wdat, p_we}) stab++;
    else stab = 1;
    if (p_m2 && !ss_m2 && rst_n && ss_we) begin
      chk("wr_setup_clocks", stab, HALF + 1);
      mem[ss_addr] = ss_wdat;
      n_wr++;
      if (exp_wr.size() == 0) chk("wr_extra", int'(ss_addr), -1);
      else begin
        e = exp_wr.pop_front();
        chk("wr_addr", int'(ss_addr), int'(e[15:8]));
        chk("wr_data", int'(ss_wdat), int'(e[7:0]));
      end
    end
    p_addr = ss_addr; p_wdat = ss_wdat; p_we = ss_we; p_m2 = ss_m2;

    if (tx_valid && p_txv && !p_xfer) chk("tx_stable", int'(tx_data), int'(p_txd));
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ((cyc / 3) % 2) == 0;
      default: tx_ready = ($urandom_range(0, 1) == 1);
    endcase
    p_xfer = tx_valid && tx_ready;
    if (p_xfer) begin
      n_tx++;
      if (exp_tx.size() == 0) chk("tx_extra", int'(tx_data), -1);
      else chk("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
    end
    p_txv = tx_valid; p_txd = tx_data;

    if (rx_q.size() > 0 && (rx_gap == 0 || $urandom_range(0, 2) != 0)) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else begin
      rx_valid = 1'b0;
    end
    if (rx_valid && rx_ready) begin
      n_rx++;
      void'(rx_q.pop_front());
    end
    if (done) n_done++;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
    chk({tag, "_rx_ready"}, int'(rx_ready), 0);
    chk({tag, "_ss_act"}, int'(ss_act), 0);
    chk({tag, "_ss_we"}, int'(ss_we), 0);
    chk({tag, "_ss_addr"}, int'(ss_addr), 0);
    chk({tag, "_ss_wdat"}, int'(ss_wdat), 0);
    chk({tag, "_ss_m2"}, int'(ss_m2), 1);
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("err_cleared_on_start", int'(err), 0);
  endtask

  task automatic wait_done(input string tag);
    int n0 = n_done;
    int t = 0;
    while (n_done == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk({tag, "_done_pulses"}, n_done - n0, 1);
  endtask

  task automatic run_save(input string tag, input int txm, input bit extra_start);
    int n0;
    exp_tx.delete();
    exp_tx.push_back(mem[ID_ADDR]);
    for (int k = 0; k < NSLOT; k++) exp_tx.push_back(mem[k]);
    tx_mode = txm;
    n0 = n_tx;
    pulse_start(1'b0);
    if (extra_start) begin
      repeat (25) @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(tag);
    chk({tag, "_tx_count"}, n_tx - n0, NSLOT + 1);
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
    chk({tag, "_ss_act_after"}, int'(ss_act), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
    @(negedge clk);
    chk({tag, "_done_one_clock"}, int'(done), 0);
  endtask

  task automatic run_restore(input string tag, input logic [7:0] hdr);
    int w0, r0;
    bit ok;
    ok = (hdr == mem[ID_ADDR]);
    rx_q.delete();
    exp_wr.delete();
    rx_q.push_back(hdr);
    for (int k = 0; k < NSLOT; k++) begin
      rx_q.push_back(pay[k]);
      if (ok) exp_wr.push_back({8'(k), pay[k]});
    end
    w0 = n_wr;
    r0 = n_rx;
    pulse_start(1'b1);
    wait_done(tag);
    chk({tag, "_writes"}, n_wr - w0, ok ? NSLOT : 0);
    chk({tag, "_rx_consumed"}, n_rx - r0, ok ? NSLOT + 1 : 1);
    chk({tag, "_err"}, int'(err), ok ? 0 : 1);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_ss_act_after"}, int'(ss_act), 0);
    if (ok) for (int k = 0; k < NSLOT; k++) chk({tag, "_mem"}, int'(mem[k]), int'(pay[k]));
    rx_q.delete();
  endtask

  initial begin
    int w0, t;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int k = 0; k < NSLOT; k++) mem[k] = 8'(8'h40 + k);
    mem[ID_ADDR] = 8'hB6;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_save("save_ready1", 0, 1'b0);
    run_save("save_toggle", 1, 1'b0);

    for (int k = 0; k < NSLOT; k++) pay[k] = 8'(k);
    run_restore("restore_seq", 8'hB6);

    for (int k = 0; k < NSLOT; k++) pay[k] = 8'($urandom_range(0, 255));
    run_restore("restore_badhdr", 8'h12);

    rx_gap = 1;
    for (int k = 0; k < NSLOT; k++) pay[k] = 8'($urandom_range(0, 255));
    run_restore("restore_rand", 8'hB6);
    rx_gap = 0;

    run_save("save_busy_start", 2, 1'b1);

    // reset in the middle of a restore, then a clean save of the partially restored mapper
    for (int k = 0; k < NSLOT; k++) pay[k] = 8'($urandom_range(0, 255));
    rx_q.delete();
    exp_wr.delete();
    rx_q.push_back(8'hB6);
    for (int k = 0; k < NSLOT; k++) begin
      rx_q.push_back(pay[k]);
      exp_wr.push_back({8'(k), pay[k]});
    end
    w0 = n_wr;
    pulse_start(1'b1);
    t = 0;
    while (n_wr - w0 < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_slot5", n_wr - w0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    rx_q.delete();
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_slot4_kept", int'(mem[4]), int'(pay[4]));
    repeat (2) @(negedge clk);
    run_save("save_after_rst", 0, 1'b0);
    chk("id_slot_untouched", int'(mem[ID_ADDR]), 8'hB6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer; initiator side of the mapper save-state (ss_*) interface.
- Save: walks the mapper's state slots, reads each via ss_rdat and streams the bytes out to the host.
- Restore: takes a byte stream from the host and writes each byte back into the mapper's slots.
- Sits between the host/USB state buffer and any mapper module.

Parameters:
- NSLOT, 18: state slots transferred, addresses 0..NSLOT-1 (0-7 regs, 8-15 bank regs, 16 irq ctr, 17 irq flags).
- ID_ADDR, 127: slot holding the mapper index; used as the stream header.
- HALF, 4: clk cycles per ss_m2 phase. Must be at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- mode  in  1  0 = save, 1 = restore; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when an operation ends, success or abort.
- err  out  1  sticky header-mismatch flag; cleared by the next accepted start.
- tx_data  out  8  save stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts byte.
- rx_data  in  8  restore stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts byte.
- ss_act  out  1  save-state access active; the mapper suspends normal operation.
- ss_we  out  1  write enable to the mapper.
- ss_addr  out  8  slot address.
- ss_wdat  out  8  write data, driven on the mapper data bus.
- ss_rdat  in  8  mapper read data; combinational from ss_addr.
- ss_m2  out  1  strobe; the mapper captures on its falling edge.

Behaviour:
- Reset values: busy=0, done=0, err=0, tx_valid=0, rx_ready=0, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, ss_m2=1.
- Bus cycle, 2*HALF clocks:
  - ss_addr, ss_wdat and ss_we are set on the first clock; ss_m2=1 for HALF clocks, then 0 for HALF clocks.
  - Read: ss_rdat is sampled on the last high-phase clock.
  - Write: ss_we is held for the whole cycle. The falling edge of ss_m2 occurs only after addr/data have been stable for HALF clocks.
  - ss_we drops and ss_addr is held one clock after the cycle ends.
- ss_act is 1 from the first bus cycle to the end of the operation, including stream-stall waits.
- FSM states: IDLE, HDR_RD, HDR_TX, HDR_CMP, SL_RD, SL_TX, SL_RX, SL_WR, FIN.
  - IDLE: on start, set busy=1, clear err, set the slot counter to 0, go to HDR_RD.
  - HDR_RD: read cycle at ID_ADDR, latch id. Then go to HDR_TX if save, HDR_CMP if restore.
  - HDR_TX: tx_data=id, tx_valid=1 until tx_ready is seen, then go to SL_RD.
  - SL_RD: read cycle at the counter address, latch the byte, go to SL_TX.
  - SL_TX: present the byte and hold it until tx_ready. Then increment the counter; go to FIN if counter==NSLOT-1, else SL_RD.
  - HDR_CMP: rx_ready=1 until rx_valid. If rx_data==id go to SL_RX; if not, set err=1 and go to FIN with no write performed.
  - SL_RX: rx_ready=1 until rx_valid, latch the byte into ss_wdat, go to SL_WR.
  - SL_WR: write cycle at the counter address; then increment, or go to FIN after the last slot.
  - FIN: ss_act=0, busy=0, done=1 for one clock, return to IDLE.
- Stream handshakes: a transfer occurs on a clock where valid&ready. tx_data is stable while tx_valid=1. rx_ready is 1 only in HDR_CMP/SL_RX, so exactly NSLOT+1 bytes are consumed per restore.
- Counter is 8 bits. There is no wrap past NSLOT-1, and ID_ADDR is never written.
- Save emits exactly NSLOT+1 bytes: header first, then slots 0..NSLOT-1 in order.
- Reset mid-operation: all outputs return to reset values immediately. A partially restored mapper is left as is; no rollback.
- A start pulse while busy=1 has no effect.

Test Plan:
- Save, tx_ready tied 1, mapper model slot k=k+0x40, id=0xB6 -> tx bytes B6,40,41,...,51 (19 bytes); done pulse; ss_act low after.
- Save with tx_ready toggling every 3 clocks -> same byte sequence, no duplicates, tx_data stable while stalled.
- Restore, header 0xB6 matching, payload 0x00..0x11 -> 18 write cycles, addr k gets data k. Check ss_we/ss_addr/ss_wdat stable at each ss_m2 fall (HALF=4: fall 4 clocks after setup). err=0.
- Restore, header 0x12 vs id 0xB6 -> err=1, zero write cycles, exactly 1 rx byte consumed, done pulse.
- rst_n asserted during slot 5 of a restore -> outputs return to reset values asynchronously. A following save starts cleanly with header first.
- start pulsed during a busy save -> ignored; byte count still 19.
